// File: rtl/uart_rx_os_if.sv
// Receive-side signal bundle for the oversampling UART receiver.
// master is the receiver itself; slave is whatever drives rx and consumes the bytes.
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output dout, done, frame_err, busy);
  modport slave  (output rx, input dout, done, frame_err, busy);
endinterface

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with OVERSAMPLE-times oversampling, mid-bit sampling,
// start-glitch rejection and framing-error reporting.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_os_if.master  bus
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TcntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned ScntW = $clog2(OVERSAMPLE);

  localparam logic [TcntW-1:0] TcntMax = TcntW'(Div - 1);
  localparam logic [ScntW-1:0] ScntMid = ScntW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScntW-1:0] ScntEnd = ScntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [ScntW-1:0]   scnt_q, scnt_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         dout_q, dout_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               tick;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    tick    = (tcnt_q == TcntMax);

    // Holding the divider at zero while idle aligns every tick to the start edge.
    if (state_q == StIdle || state_q == StWaitHigh) begin
      tcnt_d = '0;
      tick   = 1'b0;
    end else begin
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    if (tick) begin
      scnt_d = (scnt_q == ScntEnd) ? '0 : scnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick && scnt_q == ScntMid) state_d = rx_s_q ? StIdle : StData;
      end
      StData: begin
        if (tick && scnt_q == ScntEnd) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (tick && scnt_q == ScntEnd) begin
          if (rx_s_q) begin
            dout_d  = shreg_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) scnt_d = '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule
